// File: rtl/therm_bubble_fix.sv
// Flash-ADC front end: capture, two-flop sync of the comparator word, and
// 3-input majority bubble correction, with a saturating bubble counter.
module therm_bubble_fix #(
  parameter int N     = 256,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     comp_in,
  input  logic             sample_en,
  input  logic             err_clr,
  output logic [N-1:0]     therm_out,
  output logic             therm_valid,
  output logic             bubble_flag,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic             over_range
);

  logic [N-1:0]     raw_q, sync_q, therm_q;
  logic             v1_q, v2_q, valid_q, flag_q, ovr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N+1:0]     padded;
  logic [N-1:0]     corrected;
  logic             mismatch;

  // Padding of 1 below and 0 above lets the edge bits use the same majority
  // vote as interior bits without special cases.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    padded    = {1'b0, sync_q, 1'b1};
    corrected = '0;
    for (int i = 0; i < N; i++) begin
      corrected[i] = (padded[i]   & padded[i+1]) |
                     (padded[i]   & padded[i+2]) |
                     (padded[i+1] & padded[i+2]);
    end
  end

  assign mismatch = (corrected != sync_q);

  // Clear wins over increment; all-ones holds instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (err_clr) begin
      cnt_d = '0;
    end else if (v2_q && mismatch && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage reads
  // the previous cycle's value of the stage before it.
  // The wide data registers are reset too, so outputs are defined the instant
  // reset asserts rather than after the pipeline drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q   <= '0;
      sync_q  <= '0;
      therm_q <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      valid_q <= 1'b0;
      flag_q  <= 1'b0;
      ovr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (sample_en) raw_q <= comp_in;
      v1_q    <= sample_en;
      sync_q  <= raw_q;
      v2_q    <= v1_q;
      valid_q <= v2_q;
      if (v2_q) begin
        therm_q <= corrected;
        flag_q  <= mismatch;
        ovr_q   <= corrected[N-1];
      end else begin
        flag_q  <= 1'b0;
      end
      cnt_q   <= cnt_d;
    end
  end

  assign therm_out   = therm_q;
  assign therm_valid = valid_q;
  assign bubble_flag = flag_q;
  assign bubble_cnt  = cnt_q;
  assign over_range  = ovr_q;

endmodule

// File: tb/tb_therm_bubble_fix.sv
// Directed bench for therm_bubble_fix: a CNT_W=16 instance for the datapath
// and a CNT_W=4 instance sharing its inputs for counter saturation.
module tb_therm_bubble_fix;

  localparam int N = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  comp_in;
  logic          sample_en;
  logic          err_clr;

  logic [N-1:0]  therm_out, therm_out4;
  logic          therm_valid, therm_valid4;
  logic          bubble_flag, bubble_flag4;
  logic [15:0]   bubble_cnt;
  logic [3:0]    bubble_cnt4;
  logic          over_range, over_range4;

  int errors = 0;
  int checks = 0;

  therm_bubble_fix #(.N(N), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .comp_in(comp_in), .sample_en(sample_en),
    .err_clr(err_clr), .therm_out(therm_out), .therm_valid(therm_valid),
    .bubble_flag(bubble_flag), .bubble_cnt(bubble_cnt), .over_range(over_range)
  );

  therm_bubble_fix #(.N(N), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .comp_in(comp_in), .sample_en(sample_en),
    .err_clr(err_clr), .therm_out(therm_out4), .therm_valid(therm_valid4),
    .bubble_flag(bubble_flag4), .bubble_cnt(bubble_cnt4), .over_range(over_range4)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] ones(input int k);
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < k; i++) v[i] = 1'b1;
    return v;
  endfunction

  // One sample: capture at edge k, result checked #1 after edge k+2.
  // clr raises err_clr for the edge where stage 3 processes this sample.
  task automatic send(input string tag, input logic [N-1:0] d, input logic clr);
    comp_in   = d;
    sample_en = 1'b1;
    @(posedge clk); #1;
    sample_en = 1'b0;
    @(posedge clk); #1;
    check({tag, "_early_valid"}, therm_valid, 1'b0);
    err_clr = clr;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check({tag, "_valid"}, therm_valid, 1'b1);
  endtask

  task automatic pulse_end(input string tag);
    @(posedge clk); #1;
    check({tag, "_valid_end"}, therm_valid, 1'b0);
    check({tag, "_flag_end"}, bubble_flag, 1'b0);
  endtask

  logic [N-1:0] code, bub;

  initial begin
    rst_n     = 1'b0;
    comp_in   = '0;
    sample_en = 1'b0;
    err_clr   = 1'b0;
    #23;
    check("rst_therm", therm_out, '0);
    check("rst_valid", therm_valid, 1'b0);
    check("rst_cnt", bubble_cnt, '0);
    check("rst_ovr", over_range, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean code
    code = ones(100);
    send("clean", code, 1'b0);
    check("clean_therm", therm_out, code);
    check("clean_flag", bubble_flag, 1'b0);
    check("clean_cnt", bubble_cnt, 16'd0);
    check("clean_ovr", over_range, 1'b0);
    pulse_end("clean");
    check("clean_hold", therm_out, code);

    // Single bubble inside the 1-run
    bub = ones(100); bub[50] = 1'b0;
    send("hole", bub, 1'b0);
    check("hole_therm", therm_out, ones(100));
    check("hole_flag", bubble_flag, 1'b1);
    check("hole_cnt", bubble_cnt, 16'd1);
    pulse_end("hole");

    // Lone bit above the run
    bub = ones(100); bub[120] = 1'b1;
    send("lone", bub, 1'b0);
    check("lone_therm", therm_out, ones(100));
    check("lone_flag", bubble_flag, 1'b1);
    check("lone_cnt", bubble_cnt, 16'd2);
    pulse_end("lone");

    // Boundaries
    send("zero", '0, 1'b0);
    check("zero_therm", therm_out, '0);
    check("zero_flag", bubble_flag, 1'b0);
    check("zero_ovr", over_range, 1'b0);
    pulse_end("zero");

    send("full", '1, 1'b0);
    check("full_therm", therm_out, '1);
    check("full_flag", bubble_flag, 1'b0);
    check("full_ovr", over_range, 1'b1);
    pulse_end("full");

    send("bit0", ones(1), 1'b0);
    check("bit0_therm", therm_out, ones(1));
    check("bit0_flag", bubble_flag, 1'b0);
    check("bit0_ovr", over_range, 1'b0);
    check("bit0_cnt", bubble_cnt, 16'd2);
    pulse_end("bit0");

    // Streaming: code for k=10+e captured at edge e, seen after edge e+2
    for (int e = 0; e < 12; e++) begin
      if (e < 10) begin
        comp_in   = ones(10 + e);
        sample_en = 1'b1;
      end else begin
        sample_en = 1'b0;
      end
      @(posedge clk); #1;
      if (e >= 2) begin
        check($sformatf("ramp_valid_%0d", e - 2), therm_valid, 1'b1);
        check($sformatf("ramp_therm_%0d", e - 2), therm_out, ones(10 + e - 2));
      end
    end
    @(posedge clk); #1;
    check("ramp_valid_end", therm_valid, 1'b0);

    // Counter saturation: clear, then 20 bubbled samples back to back
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    check("clr_cnt16", bubble_cnt, 16'd0);
    check("clr_cnt4", bubble_cnt4, 4'd0);
    bub = ones(100); bub[50] = 1'b0;
    comp_in   = bub;
    sample_en = 1'b1;
    repeat (20) @(posedge clk);
    #1 sample_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("sat_cnt4", bubble_cnt4, 4'd15);
    check("sat_cnt16", bubble_cnt, 16'd20);
    pulse_end("sat");

    // Clear coinciding with a bubbled sample
    send("clrhit", bub, 1'b1);
    check("clrhit_cnt16", bubble_cnt, 16'd0);
    check("clrhit_cnt4", bubble_cnt4, 4'd0);
    check("clrhit_flag", bubble_flag, 1'b1);
    check("clrhit_flag4", bubble_flag4, 1'b1);
    pulse_end("clrhit");

    // Async reset with two samples in flight
    send("prerst", bub, 1'b0);
    pulse_end("prerst");
    check("prerst_cnt", bubble_cnt, 16'd1);
    comp_in   = '1;
    sample_en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    sample_en = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("arst_therm", therm_out, '0);
    check("arst_valid", therm_valid, 1'b0);
    check("arst_cnt", bubble_cnt, 16'd0);
    check("arst_ovr", over_range, 1'b0);
    check("arst_flag", bubble_flag, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk); #1;
      check($sformatf("arst_novalid_%0d", e), therm_valid, 1'b0);
    end
    send("post", ones(37), 1'b0);
    check("post_therm", therm_out, ones(37));
    pulse_end("post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
